// File: rtl/mem_rd_sched.sv
// mem_rd_sched: round-robin scheduler that issues bursts of read commands from several replay queues to one memory read port.
// Optional feature: define MEM_RD_SCHED_STATS_EN to add q_rd_cnt, a saturating count of issued commands per queue.
module mem_rd_sched #(
    parameter int NUM_QUEUES     = 4,
    parameter int MEM_ADDR_WIDTH = 19,
    parameter int BURST_CMDS     = 4,
    parameter int REPLAY_WIDTH   = 16,
    localparam int QW = NUM_QUEUES > 1 ? $clog2(NUM_QUEUES) : 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 sw_enable,
    input  logic                                 cal_done,
    input  logic [NUM_QUEUES*MEM_ADDR_WIDTH-1:0] q_addr_low,
    input  logic [NUM_QUEUES*MEM_ADDR_WIDTH-1:0] q_addr_high,
    input  logic [NUM_QUEUES-1:0]                q_enable,
    input  logic [NUM_QUEUES*REPLAY_WIDTH-1:0]   q_replay_cnt,
    input  logic [NUM_QUEUES-1:0]                fifo_afull,
    input  logic                                 mem_rd_full,
    output logic                                 mem_r_n,
    output logic [MEM_ADDR_WIDTH-1:0]            mem_ad_rd,
    output logic [QW-1:0]                        mem_rd_qid,
`ifdef MEM_RD_SCHED_STATS_EN
    output logic [NUM_QUEUES-1:0]                q_done,
    output logic [NUM_QUEUES*32-1:0]             q_rd_cnt
`else
    output logic [NUM_QUEUES-1:0]                q_done
`endif
);
    localparam int AW = MEM_ADDR_WIDTH;
    localparam int RW = REPLAY_WIDTH;
    localparam int BW = BURST_CMDS > 1 ? $clog2(BURST_CMDS) : 1;

    typedef enum logic [1:0] {IDLE, ARB, BURST} state_t;

    state_t              state, state_nx;
    logic [AW-1:0]       lo       [NUM_QUEUES];
    logic [AW-1:0]       hi       [NUM_QUEUES];
    logic [RW-1:0]       rep      [NUM_QUEUES];
    logic [AW-1:0]       ptr      [NUM_QUEUES];
    logic [RW-1:0]       pass_cnt [NUM_QUEUES];
    logic [NUM_QUEUES-1:0] elig;
    logic [QW-1:0]       grant, rr_start, pick, cand;
    logic [BW-1:0]       bcnt;
    logic                found, issue, wrap, done_hit, burst_end, clr;

    assign clr = rst || !sw_enable;

    for (genvar g = 0; g < NUM_QUEUES; g++) begin : g_unpack
        assign lo[g]   = q_addr_low[g*AW +: AW];
        assign hi[g]   = q_addr_high[g*AW +: AW];
        assign rep[g]  = q_replay_cnt[g*RW +: RW];
        assign elig[g] = q_enable[g] && !q_done[g] && !fifo_afull[g] && (lo[g] < hi[g]);
    end

    // round-robin pick: scan downward so the queue closest after rr_start wins
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int i = NUM_QUEUES - 1; i >= 0; i--) begin
            cand = QW'((int'(rr_start) + i) % NUM_QUEUES);
            if (elig[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // command issue decision for the granted queue, including wrap and replay completion
    always_comb begin
        issue     = (state == BURST) && cal_done && !mem_rd_full && q_enable[grant];
        wrap      = ptr[grant] >= hi[grant] - AW'(1);
        done_hit  = issue && wrap && (rep[grant] != '0) && (pass_cnt[grant] + RW'(1) == rep[grant]);
        burst_end = issue && (done_hit || bcnt == BW'(BURST_CMDS - 1));
    end

    // next-state: losing calibration always returns to IDLE; a disabled grantee ends its burst
    always_comb begin
        state_nx = state;
        if (!cal_done)
            state_nx = IDLE;
        else if (state == IDLE)
            state_nx = ARB;
        else if (state == ARB && found)
            state_nx = BURST;
        else if (state == BURST && (!q_enable[grant] || burst_end))
            state_nx = ARB;
    end

    // state register
    always_ff @(posedge clk) begin
        state <= clr ? IDLE : state_nx;
    end

    // registered command outputs, grant and round-robin bookkeeping
    always_ff @(posedge clk) begin
        if (clr) begin
            mem_r_n    <= 1'b1;
            mem_ad_rd  <= '0;
            mem_rd_qid <= '0;
            grant      <= '0;
            rr_start   <= '0;
            bcnt       <= '0;
        end else begin
            mem_r_n <= !issue;
            if (issue) begin
                mem_ad_rd  <= ptr[grant];
                mem_rd_qid <= grant;
                bcnt       <= bcnt + BW'(1);
            end
            if (state == ARB && cal_done && found) begin
                grant    <= pick;
                rr_start <= (pick == QW'(NUM_QUEUES - 1)) ? '0 : pick + QW'(1);
                bcnt     <= '0;
            end
        end
    end

    // per-queue address pointer, pass count and done flag; a disabled queue rewinds immediately
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_QUEUES; i++) begin
            if (clr || !q_enable[i]) begin
                ptr[i]      <= lo[i];
                pass_cnt[i] <= '0;
                q_done[i]   <= 1'b0;
            end else if (issue && grant == QW'(i)) begin
                ptr[i] <= wrap ? lo[i] : ptr[i] + AW'(1);
                if (wrap)
                    pass_cnt[i] <= pass_cnt[i] + RW'(1);
                if (done_hit)
                    q_done[i] <= 1'b1;
            end
        end
    end

`ifdef MEM_RD_SCHED_STATS_EN
    logic [31:0] rd_cnt [NUM_QUEUES];

    // saturating issued-command counters
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_QUEUES; i++) begin
            if (clr)
                rd_cnt[i] <= '0;
            else if (issue && grant == QW'(i) && rd_cnt[i] != '1)
                rd_cnt[i] <= rd_cnt[i] + 32'd1;
        end
    end

    for (genvar g = 0; g < NUM_QUEUES; g++) begin : g_stats
        assign q_rd_cnt[g*32 +: 32] = rd_cnt[g];
    end
`endif

endmodule

// File: tb/tb_mem_rd_sched.sv
// tb_mem_rd_sched: directed scenarios checked against a transaction-level model of the read scheduler.
`timescale 1ns/1ps
module tb_mem_rd_sched;
    localparam int NQ = 4;
    localparam int AW = 19;
    localparam int RW = 16;
    localparam int BC = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sw_enable = 1'b1;
    logic cal_done = 1'b0;
    logic mem_rd_full = 1'b0;
    logic [NQ-1:0] q_enable = '0;
    logic [NQ-1:0] fifo_afull = '0;
    logic [NQ*AW-1:0] q_addr_low, q_addr_high;
    logic [NQ*RW-1:0] q_replay_cnt;
    logic mem_r_n;
    logic [AW-1:0] mem_ad_rd;
    logic [1:0] mem_rd_qid;
    logic [NQ-1:0] q_done;

    logic [AW-1:0] lo [NQ];
    logic [AW-1:0] hi [NQ];
    logic [RW-1:0] rep [NQ];

    for (genvar g = 0; g < NQ; g++) begin : g_pack
        assign q_addr_low[g*AW +: AW]   = lo[g];
        assign q_addr_high[g*AW +: AW]  = hi[g];
        assign q_replay_cnt[g*RW +: RW] = rep[g];
    end

    mem_rd_sched dut (
        .clk(clk), .rst(rst), .sw_enable(sw_enable), .cal_done(cal_done),
        .q_addr_low(q_addr_low), .q_addr_high(q_addr_high), .q_enable(q_enable),
        .q_replay_cnt(q_replay_cnt), .fifo_afull(fifo_afull), .mem_rd_full(mem_rd_full),
        .mem_r_n(mem_r_n), .mem_ad_rd(mem_ad_rd), .mem_rd_qid(mem_rd_qid), .q_done(q_done)
    );

    always #5 clk = ~clk;

    int m_ptr [NQ];
    int m_pass [NQ];
    int m_rr;
    logic [NQ-1:0] m_done;
    logic [AW+1:0] exp_q [$];
    int nchk = 0, nfail = 0, ncmd = 0, cyc = 0, first_cyc = 0, last_cyc = 0;
    logic checking = 1'b0;
    logic [AW-1:0] cmd_addr [128];
    int cmd_qid [128];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        nchk++;
        if (act !== expv) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, expv);
        end
    endtask

    task automatic model_reset();
        for (int q = 0; q < NQ; q++) begin
            m_ptr[q]  = int'(lo[q]);
            m_pass[q] = 0;
        end
        m_done = '0;
        m_rr = 0;
        exp_q.delete();
    endtask

    // one grant: next eligible queue after the last grant, up to BC commands, stopping when its replays complete
    task automatic gen_burst();
        int g = -1;
        for (int k = 0; k < NQ; k++) begin
            int q = (m_rr + k) % NQ;
            if (g < 0 && q_enable[q] && !m_done[q] && !fifo_afull[q] && lo[q] < hi[q]) g = q;
        end
        if (g < 0) return;
        m_rr = (g + 1) % NQ;
        for (int n = 0; n < BC && !m_done[g]; n++) begin
            exp_q.push_back({2'(g), AW'(m_ptr[g])});
            if (m_ptr[g] == int'(hi[g]) - 1) begin
                m_ptr[g] = int'(lo[g]);
                m_pass[g]++;
                if (rep[g] != 0 && m_pass[g] == int'(rep[g])) m_done[g] = 1'b1;
            end else begin
                m_ptr[g]++;
            end
        end
    endtask

    task automatic wait_cmds(input int n, input string nm);
        int t = 0;
        while (ncmd < n && t < 2000) begin
            @(posedge clk);
            #2;
            t++;
        end
        nchk++;
        if (ncmd < n) begin
            nfail++;
            $display("FAIL %s: timeout with %0d commands, expected %0d", nm, ncmd, n);
        end
    endtask

    task automatic start_scen(input logic [NQ-1:0] en);
        @(negedge clk);
        checking = 1'b0;
        cal_done = 1'b0;
        rst = 1'b1;
        q_enable = en;
        repeat (2) @(negedge clk);
        model_reset();
        ncmd = 0;
        rst = 1'b0;
        checking = 1'b1;
        @(negedge clk);
        cal_done = 1'b1;
    endtask

    // every cycle: each issued command must be the model's next one; with no burst pending q_done must match
    always begin
        logic [AW+1:0] e;
        @(posedge clk);
        #1;
        cyc++;
        if (checking) begin
            if (!mem_r_n) begin
                if (exp_q.size() == 0) gen_burst();
                if (exp_q.size() == 0) begin
                    nchk++;
                    nfail++;
                    $display("FAIL unexpected_cmd: got command qid %0d addr 0x%0h, expected none", mem_rd_qid, mem_ad_rd);
                end else begin
                    e = exp_q.pop_front();
                    chk("cmd_addr", 32'(mem_ad_rd), 32'(e[AW-1:0]));
                    chk("cmd_qid", 32'(mem_rd_qid), 32'(e[AW+1:AW]));
                end
                if (ncmd < 128) begin
                    cmd_addr[ncmd] = mem_ad_rd;
                    cmd_qid[ncmd]  = int'(mem_rd_qid);
                end
                if (ncmd == 0) first_cyc = cyc;
                last_cyc = cyc;
                ncmd++;
            end
            if (exp_q.size() == 0) chk("q_done", 32'(q_done), 32'(m_done));
        end
    end

    initial begin
        for (int q = 0; q < NQ; q++) begin
            lo[q] = '0;
            hi[q] = '0;
            rep[q] = '0;
        end
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        chk("rst_r_n", 32'(mem_r_n), 32'd1);
        chk("rst_addr", 32'(mem_ad_rd), 32'd0);
        chk("rst_qid", 32'(mem_rd_qid), 32'd0);
        chk("rst_done", 32'(q_done), 32'd0);

        // single queue, two passes over 8 addresses
        lo[0] = 19'h100; hi[0] = 19'h108; rep[0] = 16'd2;
        start_scen(4'b0001);
        wait_cmds(16, "a_cmds");
        repeat (20) @(negedge clk);
        chk("a_total", 32'(ncmd), 32'd16);
        chk("a_first", 32'(cmd_addr[0]), 32'h100);
        chk("a_mid", 32'(cmd_addr[8]), 32'h100);
        chk("a_last", 32'(cmd_addr[15]), 32'h107);
        chk("a_span", 32'(last_cyc - first_cyc), 32'd18);
        chk("a_done", 32'(q_done), 32'd1);
        chk("a_idle", 32'(mem_r_n), 32'd1);

        // replay completes in the middle of a burst
        lo[1] = 19'h20; hi[1] = 19'h26; rep[1] = 16'd1;
        start_scen(4'b0010);
        wait_cmds(6, "g_cmds");
        repeat (10) @(negedge clk);
        chk("g_total", 32'(ncmd), 32'd6);
        chk("g_last", 32'(cmd_addr[5]), 32'h25);
        chk("g_done", 32'(q_done), 32'b0010);

        // four queues round robin; queue 3 sits at the top of the address space
        lo[0] = 19'h0;     hi[0] = 19'h10;    rep[0] = 16'd0;
        lo[1] = 19'h1000;  hi[1] = 19'h1010;  rep[1] = 16'd0;
        lo[2] = 19'h2000;  hi[2] = 19'h2010;  rep[2] = 16'd0;
        lo[3] = 19'h7FFFC; hi[3] = 19'h7FFFF; rep[3] = 16'd0;
        start_scen(4'b1111);
        wait_cmds(20, "b_cmds");
        chk("b_grant0", 32'(cmd_qid[0]), 32'd0);
        chk("b_grant1", 32'(cmd_qid[4]), 32'd1);
        chk("b_grant2", 32'(cmd_qid[8]), 32'd2);
        chk("b_grant3", 32'(cmd_qid[12]), 32'd3);
        chk("b_grant4", 32'(cmd_qid[16]), 32'd0);
        chk("b_top", 32'(cmd_addr[14]), 32'h7FFFE);
        chk("b_topwrap", 32'(cmd_addr[15]), 32'h7FFFC);
        chk("b_resume", 32'(cmd_addr[16]), 32'h4);

        // command queue full for three cycles mid-burst
        lo[0] = 19'h200; hi[0] = 19'h300;
        start_scen(4'b0001);
        wait_cmds(2, "c_pre");
        @(negedge clk);
        mem_rd_full = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #2;
            chk("c_stall", 32'(mem_r_n), 32'd1);
        end
        @(negedge clk);
        mem_rd_full = 1'b0;
        wait_cmds(4, "c_rest");
        @(posedge clk);
        #2;
        chk("c_gap", 32'(mem_r_n), 32'd1);
        wait_cmds(5, "c_next");
        chk("c_addr2", 32'(cmd_addr[2]), 32'h202);
        chk("c_addr3", 32'(cmd_addr[3]), 32'h203);
        chk("c_addr4", 32'(cmd_addr[4]), 32'h204);

        // downstream FIFO of queue 1 almost full, released mid-burst of queue 0
        lo[0] = 19'h0;   hi[0] = 19'h40;
        lo[1] = 19'h400; hi[1] = 19'h440;
        fifo_afull = 4'b0010;
        start_scen(4'b0011);
        wait_cmds(14, "d_pre");
        chk("d_only0a", 32'(cmd_qid[8]), 32'd0);
        chk("d_only0b", 32'(cmd_qid[12]), 32'd0);
        @(negedge clk);
        fifo_afull = 4'b0000;
        wait_cmds(17, "d_post");
        chk("d_q1", 32'(cmd_qid[16]), 32'd1);
        chk("d_q1addr", 32'(cmd_addr[16]), 32'h400);
        chk("d_q0addr", 32'(cmd_addr[12]), 32'hC);

        // software disable mid-burst, then restart from the region start
        lo[2] = 19'h5000; hi[2] = 19'h5100;
        start_scen(4'b0100);
        wait_cmds(2, "e_pre");
        @(negedge clk);
        sw_enable = 1'b0;
        model_reset();
        @(posedge clk);
        #2;
        chk("e_off", 32'(mem_r_n), 32'd1);
        chk("e_addr", 32'(mem_ad_rd), 32'd0);
        repeat (3) @(negedge clk);
        ncmd = 0;
        sw_enable = 1'b1;
        wait_cmds(6, "e_restart");
        chk("e_first", 32'(cmd_addr[0]), 32'h5000);
        chk("e_sixth", 32'(cmd_addr[5]), 32'h5005);

        // unlimited replay over four addresses
        lo[3] = 19'h10; hi[3] = 19'h14;
        start_scen(4'b1000);
        wait_cmds(100, "f_cmds");
        chk("f_done", 32'(q_done), 32'd0);
        chk("f_wrap", 32'(cmd_addr[4]), 32'h10);
        chk("f_last", 32'(cmd_addr[99]), 32'h13);

        @(negedge clk);
        checking = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
